// File: rtl/condlogic.sv
// rtl/condlogic.sv - conditional-execution stage: NZCV flag register, condition check, write-strobe gating
module condlogic #(
  parameter logic NV_ALWAYS = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx
);

  logic [3:0] flags_q;
  logic       condex_comb;
  logic       condexr;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  // Evaluated on the stored flags only, so a flag-setting instruction never affects its own condition.
  always_comb begin
    condex_comb = 1'b0;
    case (Cond)
      4'b0000: condex_comb = z;
      4'b0001: condex_comb = ~z;
      4'b0010: condex_comb = c;
      4'b0011: condex_comb = ~c;
      4'b0100: condex_comb = n;
      4'b0101: condex_comb = ~n;
      4'b0110: condex_comb = v;
      4'b0111: condex_comb = ~v;
      4'b1000: condex_comb = c & ~z;
      4'b1001: condex_comb = ~c | z;
      4'b1010: condex_comb = ~(n ^ v);
      4'b1011: condex_comb = n ^ v;
      4'b1100: condex_comb = ~z & ~(n ^ v);
      4'b1101: condex_comb = z | (n ^ v);
      4'b1110: condex_comb = 1'b1;
      4'b1111: condex_comb = NV_ALWAYS;
      default: condex_comb = 1'b0;
    endcase
  end

  // N,Z and C,V halves update independently so logical ops can leave C,V untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q <= 4'b0000;
      condexr <= 1'b0;
    end else begin
      condexr <= condex_comb;
      if (FlagW[1] & condexr) flags_q[3:2] <= ALUFlags[3:2];
      if (FlagW[0] & condexr) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  // Strobes drop as soon as reset asserts, even in the middle of an instruction.
  assign PCWrite  = reset & ((PCS & condexr) | NextPC);
  assign RegWrite = reset & RegW & condexr;
  assign MemWrite = reset & MemW & condexr;
  assign Flags    = flags_q;
  assign CondEx   = condexr;

endmodule
